// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcode constants, state encodings and datapath select encodings for the
// multi-cycle RV32I controller and its datapath.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [2:0] ST_IF = 3'd0;
  localparam logic [2:0] ST_ID = 3'd1;
  localparam logic [2:0] ST_EX = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB = 3'd4;
  localparam logic [2:0] ST_JALR_WB = 3'd5;
  localparam logic [2:0] ST_PC_INC = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic ALU_A_PC = 1'b0;
  localparam logic ALU_A_RS1 = 1'b1;
  localparam logic [1:0] ALU_B_RS2 = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_IMM = 2'd2;
  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd2;
  localparam logic PC_SRC_ALU = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       pc_source;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = 14'd0;

  // ECALL is deliberately outside this set: it halts without flagging illegal.
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_R_TYPE, OP_I_ARITH, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: opcode_supported = 1'b1;
      default:                    opcode_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the controller and the datapath: IR/ALU/memory status in,
// control word and status out. master = datapath side, slave = controller.
interface multicycle_control_unit_if;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  mem_to_reg;
  logic        pc_source;
  logic        is_halted;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    output opcode, alu_bcond, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_source,
           is_halted, illegal, retired
  );

  modport slave (
    input  opcode, alu_bcond, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_source,
           is_halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// control_word_decoder: pure combinational map from (state, opcode, alu_bcond,
// mem_ready) to the datapath control word.
module control_word_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0]  state,
  input  logic [6:0]  opcode,
  input  logic        alu_bcond,
  input  logic        mem_ready,
  output ctrl_word_t  word
);

  // Per-state control word; anything not set stays at the idle value.
  always_comb begin
    word = CTRL_IDLE;
    case (state)
      ST_IF: begin
        word.mem_read = 1'b1;
        word.ir_write = mem_ready;
      end
      ST_ID: begin
        word.alu_src_a = ALU_A_PC;
        word.alu_src_b = ALU_B_IMM;
        word.alu_op    = ALU_OP_ADD;
      end
      ST_EX: begin
        case (opcode)
          OP_R_TYPE: begin
            word.alu_src_a = ALU_A_RS1;
            word.alu_src_b = ALU_B_RS2;
            word.alu_op    = ALU_OP_FUNCT;
          end
          OP_I_ARITH: begin
            word.alu_src_a = ALU_A_RS1;
            word.alu_src_b = ALU_B_IMM;
            word.alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            word.alu_src_a = ALU_A_RS1;
            word.alu_src_b = ALU_B_IMM;
            word.alu_op    = ALU_OP_ADD;
          end
          OP_BRANCH: begin
            word.alu_src_a = ALU_A_RS1;
            word.alu_src_b = ALU_B_RS2;
            word.alu_op    = ALU_OP_BRANCH;
            word.pc_write  = alu_bcond;
            word.pc_source = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_ALU;
          end
          OP_JAL: begin
            // Link value is the live PC+4; ALUOut already holds PC+imm from ID.
            word.alu_src_a  = ALU_A_PC;
            word.alu_src_b  = ALU_B_FOUR;
            word.alu_op     = ALU_OP_ADD;
            word.reg_write  = 1'b1;
            word.mem_to_reg = WB_ALU;
            word.pc_write   = 1'b1;
            word.pc_source  = PC_SRC_ALUOUT;
          end
          default: word = CTRL_IDLE;
        endcase
      end
      ST_MEM: begin
        word.iord      = 1'b1;
        word.mem_read  = (opcode == OP_LOAD);
        word.mem_write = (opcode == OP_STORE);
      end
      ST_WB: begin
        word.reg_write  = 1'b1;
        word.mem_to_reg = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        word.alu_src_a  = ALU_A_PC;
        word.alu_src_b  = ALU_B_FOUR;
        word.alu_op     = ALU_OP_ADD;
        word.pc_write   = 1'b1;
        word.pc_source  = PC_SRC_ALU;
      end
      ST_JALR_WB: begin
        word.alu_src_a  = ALU_A_PC;
        word.alu_src_b  = ALU_B_FOUR;
        word.alu_op     = ALU_OP_ADD;
        word.reg_write  = 1'b1;
        word.mem_to_reg = WB_ALU;
        word.pc_write   = 1'b1;
        word.pc_source  = PC_SRC_ALUOUT;
      end
      ST_PC_INC: begin
        word.alu_src_a = ALU_A_PC;
        word.alu_src_b = ALU_B_FOUR;
        word.alu_op    = ALU_OP_ADD;
        word.pc_write  = 1'b1;
        word.pc_source = PC_SRC_ALU;
      end
      ST_HALT: word = CTRL_IDLE;
      default: word = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: state register, next-state logic, retired
// counter and halt/illegal flags; the control word comes from the decoder.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.slave  bus
);

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic        retire_s;
  logic [31:0] retired_r;
  logic        is_halted_r;
  logic        illegal_r;
  ctrl_word_t  word_s;
  ctrl_word_t  gated_s;

  control_word_decoder u_decoder (
    .state     (state_r),
    .opcode    (bus.opcode),
    .alu_bcond (bus.alu_bcond),
    .mem_ready (bus.mem_ready),
    .word      (word_s)
  );

  // Next-state selection.
  always_comb begin
    next_state_s = ST_IF;
    case (state_r)
      ST_IF:  next_state_s = bus.mem_ready ? ST_ID : ST_IF;
      ST_ID: begin
        if (opcode_supported(bus.opcode)) begin
          next_state_s = ST_EX;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      ST_EX: begin
        case (bus.opcode)
          OP_R_TYPE, OP_I_ARITH: next_state_s = ST_WB;
          OP_LOAD, OP_STORE:     next_state_s = ST_MEM;
          OP_BRANCH:             next_state_s = bus.alu_bcond ? ST_IF : ST_PC_INC;
          OP_JAL:                next_state_s = ST_IF;
          OP_JALR:               next_state_s = ST_JALR_WB;
          default:               next_state_s = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (!bus.mem_ready) begin
          next_state_s = ST_MEM;
        end else if (bus.opcode == OP_LOAD) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_PC_INC;
        end
      end
      ST_WB, ST_JALR_WB, ST_PC_INC: next_state_s = ST_IF;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_IF;
    endcase
  end

  // An instruction retires on entry to IF or HALT, not while IF waits on memory.
  always_comb begin
    if ((next_state_s != state_r) &&
        ((next_state_s == ST_IF) || (next_state_s == ST_HALT))) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

  // State, retired counter and terminal flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IF;
      retired_r   <= 32'd0;
      is_halted_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        retired_r <= retired_r + 32'd1;
      end
      if ((state_r == ST_ID) && (next_state_s == ST_HALT)) begin
        is_halted_r <= (bus.opcode == OP_ECALL);
        illegal_r   <= (bus.opcode != OP_ECALL);
      end
    end
  end

  // Reset is asynchronous, so the strobes are squashed directly rather than via state.
  always_comb begin
    if (!reset) begin
      gated_s = CTRL_IDLE;
    end else begin
      gated_s = word_s;
    end
  end

  assign bus.pc_write   = gated_s.pc_write;
  assign bus.ir_write   = gated_s.ir_write;
  assign bus.reg_write  = gated_s.reg_write;
  assign bus.mem_read   = gated_s.mem_read;
  assign bus.mem_write  = gated_s.mem_write;
  assign bus.iord       = gated_s.iord;
  assign bus.alu_src_a  = gated_s.alu_src_a;
  assign bus.alu_src_b  = gated_s.alu_src_b;
  assign bus.alu_op     = gated_s.alu_op;
  assign bus.mem_to_reg = gated_s.mem_to_reg;
  assign bus.pc_source  = gated_s.pc_source;
  assign bus.is_halted  = is_halted_r;
  assign bus.illegal    = illegal_r;
  assign bus.retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each driven cycle pushes its
// hand-computed control word; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_src_a,
  //  alu_src_b[1:0], alu_op[1:0], mem_to_reg[1:0], pc_source}
  function automatic logic [13:0] cw(input logic pw, input logic irw, input logic rw,
                                     input logic mr, input logic mw, input logic iord,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] m2r,
                                     input logic psrc);
    cw = {pw, irw, rw, mr, mw, iord, asa, asb, aop, m2r, psrc};
  endfunction

  localparam logic [13:0] W_ZERO  = 14'd0;
  localparam logic [13:0] W_IF    = cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_IFW   = cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_ID    = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_EXR   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0);
  localparam logic [13:0] W_EXI   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0);
  localparam logic [13:0] W_EXA   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_BRT   = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b1);
  localparam logic [13:0] W_BRN   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0);
  localparam logic [13:0] W_LINK  = cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2, 1'b1);
  localparam logic [13:0] W_MEMLD = cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_MEMST = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_WBA   = cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);
  localparam logic [13:0] W_WBL   = cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 1'b0);
  localparam logic [13:0] W_PCI   = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);

  localparam logic [6:0] O_ADD = 7'h33;
  localparam logic [6:0] O_ADDI = 7'h13;
  localparam logic [6:0] O_LW = 7'h03;
  localparam logic [6:0] O_SW = 7'h23;
  localparam logic [6:0] O_BEQ = 7'h63;
  localparam logic [6:0] O_JAL = 7'h6F;
  localparam logic [6:0] O_JALR = 7'h67;
  localparam logic [6:0] O_ECALL = 7'h73;
  localparam logic [6:0] O_BAD = 7'h7F;

  typedef struct packed {
    logic [63:0] name;
    logic [13:0] word;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [13:0] act_word;
  assign act_word = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                     bus.mem_write, bus.iord, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_op, bus.mem_to_reg, bus.pc_source};

  // Monitor: every cycle the DUT presents a control word; pop and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act_word !== e.word || bus.is_halted !== e.halted ||
          bus.illegal !== e.illegal || bus.retired !== e.retired) begin
        errors++;
        $display("FAIL %s: got word=%b halted=%b illegal=%b retired=%0d, expected word=%b halted=%b illegal=%b retired=%0d",
                 e.name, act_word, bus.is_halted, bus.illegal, bus.retired,
                 e.word, e.halted, e.illegal, e.retired);
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic bc, input logic mr,
                      input logic [13:0] w, input logic h, input logic il,
                      input logic [31:0] ret, input logic [63:0] nm);
    exp_t e;
    bus.opcode = op;
    bus.alu_bcond = bc;
    bus.mem_ready = mr;
    e.name = nm;
    e.word = w;
    e.halted = h;
    e.illegal = il;
    e.retired = ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode = 7'd0;
    bus.alu_bcond = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(O_ADD, 1'b0, 1'b1, W_ZERO, 1'b0, 1'b0, 32'd0, "rst");
    reset = 1'b1;

    // ADD: 4 cycles
    step(O_ADD, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd0, "add_if");
    step(O_ADD, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd0, "add_id");
    step(O_ADD, 1'b0, 1'b1, W_EXR,  1'b0, 1'b0, 32'd0, "add_ex");
    step(O_ADD, 1'b0, 1'b1, W_WBA,  1'b0, 1'b0, 32'd0, "add_wb");
    // LW with two MEM wait cycles: 7 cycles
    step(O_LW, 1'b0, 1'b1, W_IF,    1'b0, 1'b0, 32'd1, "lw_if");
    step(O_LW, 1'b0, 1'b1, W_ID,    1'b0, 1'b0, 32'd1, "lw_id");
    step(O_LW, 1'b0, 1'b1, W_EXA,   1'b0, 1'b0, 32'd1, "lw_ex");
    step(O_LW, 1'b0, 1'b0, W_MEMLD, 1'b0, 1'b0, 32'd1, "lw_mem0");
    step(O_LW, 1'b0, 1'b0, W_MEMLD, 1'b0, 1'b0, 32'd1, "lw_mem1");
    step(O_LW, 1'b0, 1'b1, W_MEMLD, 1'b0, 1'b0, 32'd1, "lw_mem2");
    step(O_LW, 1'b0, 1'b1, W_WBL,   1'b0, 1'b0, 32'd1, "lw_wb");
    // BEQ taken: 3 cycles
    step(O_BEQ, 1'b1, 1'b1, W_IF,   1'b0, 1'b0, 32'd2, "bt_if");
    step(O_BEQ, 1'b1, 1'b1, W_ID,   1'b0, 1'b0, 32'd2, "bt_id");
    step(O_BEQ, 1'b1, 1'b1, W_BRT,  1'b0, 1'b0, 32'd2, "bt_ex");
    // BEQ not taken: 4 cycles
    step(O_BEQ, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd3, "bn_if");
    step(O_BEQ, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd3, "bn_id");
    step(O_BEQ, 1'b0, 1'b1, W_BRN,  1'b0, 1'b0, 32'd3, "bn_ex");
    step(O_BEQ, 1'b0, 1'b1, W_PCI,  1'b0, 1'b0, 32'd3, "bn_pci");
    // JAL with one fetch wait
    step(O_JAL, 1'b0, 1'b0, W_IFW,  1'b0, 1'b0, 32'd4, "jal_ifw");
    step(O_JAL, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd4, "jal_if");
    step(O_JAL, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd4, "jal_id");
    step(O_JAL, 1'b0, 1'b1, W_LINK, 1'b0, 1'b0, 32'd4, "jal_ex");
    // JALR
    step(O_JALR, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd5, "jalr_if");
    step(O_JALR, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd5, "jalr_id");
    step(O_JALR, 1'b0, 1'b1, W_EXA,  1'b0, 1'b0, 32'd5, "jalr_ex");
    step(O_JALR, 1'b0, 1'b1, W_LINK, 1'b0, 1'b0, 32'd5, "jalr_wb");
    // ADDI
    step(O_ADDI, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd6, "addi_if");
    step(O_ADDI, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd6, "addi_id");
    step(O_ADDI, 1'b0, 1'b1, W_EXI,  1'b0, 1'b0, 32'd6, "addi_ex");
    step(O_ADDI, 1'b0, 1'b1, W_WBA,  1'b0, 1'b0, 32'd6, "addi_wb");
    // SW zero-wait: 5 cycles
    step(O_SW, 1'b0, 1'b1, W_IF,    1'b0, 1'b0, 32'd7, "sw_if");
    step(O_SW, 1'b0, 1'b1, W_ID,    1'b0, 1'b0, 32'd7, "sw_id");
    step(O_SW, 1'b0, 1'b1, W_EXA,   1'b0, 1'b0, 32'd7, "sw_ex");
    step(O_SW, 1'b0, 1'b1, W_MEMST, 1'b0, 1'b0, 32'd7, "sw_mem");
    step(O_SW, 1'b0, 1'b1, W_PCI,   1'b0, 1'b0, 32'd7, "sw_pci");
    // SW interrupted by reset during a MEM wait
    step(O_SW, 1'b0, 1'b1, W_IF,    1'b0, 1'b0, 32'd8, "sw2_if");
    step(O_SW, 1'b0, 1'b1, W_ID,    1'b0, 1'b0, 32'd8, "sw2_id");
    step(O_SW, 1'b0, 1'b1, W_EXA,   1'b0, 1'b0, 32'd8, "sw2_ex");
    step(O_SW, 1'b0, 1'b0, W_MEMST, 1'b0, 1'b0, 32'd8, "sw2_mem");
    reset = 1'b0;
    step(O_SW, 1'b0, 1'b0, W_ZERO,  1'b0, 1'b0, 32'd0, "sw2_rst");
    reset = 1'b1;
    // ECALL
    step(O_ECALL, 1'b0, 1'b1, W_IF, 1'b0, 1'b0, 32'd0, "ec_if");
    step(O_ECALL, 1'b0, 1'b1, W_ID, 1'b0, 1'b0, 32'd0, "ec_id");
    for (int i = 0; i < 20; i++) begin
      step(O_ECALL, i[0], i[1], W_ZERO, 1'b1, 1'b0, 32'd1, "ec_halt");
    end
    // Illegal opcode
    reset = 1'b0;
    step(O_BAD, 1'b0, 1'b1, W_ZERO, 1'b0, 1'b0, 32'd0, "il_rst");
    reset = 1'b1;
    step(O_BAD, 1'b0, 1'b1, W_IF,   1'b0, 1'b0, 32'd0, "il_if");
    step(O_BAD, 1'b0, 1'b1, W_ID,   1'b0, 1'b0, 32'd0, "il_id");
    for (int i = 0; i < 3; i++) begin
      step(O_BAD, 1'b1, 1'b1, W_ZERO, 1'b0, 1'b1, 32'd1, "il_halt");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
